// File: rtl/npu_acc_pkg.sv
// Shared definitions for the NPU accumulate path: FSM state encoding,
// accumulator width and the signed 16-bit saturation limits.
package npu_acc_pkg;

  localparam int ACC_W = 24;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACC   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_OUT   = 2'd3
  } acc_state_e;

  localparam logic signed [15:0] SAT_MAX = 16'sh7FFF;
  localparam logic signed [15:0] SAT_MIN = 16'sh8000;

endpackage

// File: rtl/sat_s24_s16.sv
// Combinational clip of a wide signed value to signed 16 bits, with a flag
// telling whether clipping happened.
module sat_s24_s16
  import npu_acc_pkg::*;
#(
  parameter int IN_W = ACC_W
) (
  input  logic signed [IN_W-1:0] din_i,
  output logic        [15:0]     dout_o,
  output logic                   clip_o
);

  // Limits sign-extended to the input width so the compare is full-width.
  localparam logic signed [IN_W-1:0] MAX_EXT = {{(IN_W-16){1'b0}}, SAT_MAX};
  localparam logic signed [IN_W-1:0] MIN_EXT = {{(IN_W-16){1'b1}}, SAT_MIN};

  // Pick the positive limit, negative limit, or pass the low 16 bits through.
  always_comb begin
    dout_o = din_i[15:0];
    clip_o = 1'b0;
    if (din_i > MAX_EXT) begin
      dout_o = SAT_MAX;
      clip_o = 1'b1;
    end else if (din_i < MIN_EXT) begin
      dout_o = SAT_MIN;
      clip_o = 1'b1;
    end else begin
      dout_o = din_i[15:0];
      clip_o = 1'b0;
    end
  end

endmodule

// File: rtl/mac_acc_16b.sv
// Signed 8x8 multiply-accumulate over a programmable number of terms with
// optional bias; the total is saturated to signed 16 bits and handed out on
// a valid/ready port. One product register sits between the multiplier and
// the accumulator, so the last product is folded in during DRAIN.
module mac_acc_16b
  import npu_acc_pkg::*;
#(
  parameter int ACC_W = npu_acc_pkg::ACC_W,
  parameter int LEN_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clr,
  input  logic             i_start,
  input  logic [LEN_W-1:0] i_len,
  input  logic             i_bias_en,
  input  logic [15:0]      i_bias,
  input  logic             i_a_vld,
  input  logic [7:0]       i_a,
  input  logic [7:0]       i_b,
  output logic             o_a_rdy,
  output logic [15:0]      o_dat,
  output logic             o_sat,
  output logic             o_vld,
  input  logic             i_rdy,
  output logic             o_busy
);

  localparam int CNT_W = LEN_W + 1;
  localparam logic [CNT_W-1:0] CNT_ONE  = {{LEN_W{1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_FULL = {1'b1, {LEN_W{1'b0}}};

  acc_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [15:0]       p_q, p_d;
  logic              p_v_q, p_v_d;
  logic              a_rdy_q, a_rdy_d;
  logic [15:0]       dat_q, dat_d;
  logic              sat_q, sat_d;
  logic              vld_q, vld_d;

  logic              hs_s;
  logic signed [15:0] prod_s;
  logic [ACC_W-1:0]  p_ext_s;
  logic [ACC_W-1:0]  bias_ext_s;
  logic [ACC_W-1:0]  drain_sum_s;
  logic [15:0]       sat_val_s;
  logic              sat_clip_s;

  assign hs_s        = i_a_vld & a_rdy_q;
  assign prod_s      = $signed(i_a) * $signed(i_b);
  assign p_ext_s     = {{(ACC_W-16){p_q[15]}}, p_q};
  assign bias_ext_s  = {{(ACC_W-16){i_bias[15]}}, i_bias};
  assign drain_sum_s = acc_q + (p_v_q ? p_ext_s : {ACC_W{1'b0}});

  sat_s24_s16 #(
    .IN_W (ACC_W)
  ) u_sat (
    .din_i  (drain_sum_s),
    .dout_o (sat_val_s),
    .clip_o (sat_clip_s)
  );

  // Next-state logic; abort wins over every transition and handshake.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    p_d     = p_q;
    p_v_d   = 1'b0;
    a_rdy_d = a_rdy_q;
    dat_d   = dat_q;
    sat_d   = sat_q;
    vld_d   = vld_q;
    if (i_clr) begin
      state_d = ST_IDLE;
      a_rdy_d = 1'b0;
      vld_d   = 1'b0;
      p_v_d   = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (i_start) begin
            cnt_d   = (i_len == {LEN_W{1'b0}}) ? CNT_FULL : {1'b0, i_len};
            acc_d   = i_bias_en ? bias_ext_s : {ACC_W{1'b0}};
            p_v_d   = 1'b0;
            a_rdy_d = 1'b1;
            state_d = ST_ACC;
          end else begin
            a_rdy_d = 1'b0;
          end
        end
        ST_ACC: begin
          if (p_v_q) begin
            acc_d = acc_q + p_ext_s;
          end else begin
            acc_d = acc_q;
          end
          if (hs_s) begin
            p_d   = prod_s;
            p_v_d = 1'b1;
            cnt_d = cnt_q - CNT_ONE;
            if (cnt_q == CNT_ONE) begin
              a_rdy_d = 1'b0;
              state_d = ST_DRAIN;
            end else begin
              a_rdy_d = 1'b1;
            end
          end else begin
            p_v_d = 1'b0;
          end
        end
        ST_DRAIN: begin
          dat_d   = sat_val_s;
          sat_d   = sat_clip_s;
          vld_d   = 1'b1;
          state_d = ST_OUT;
        end
        ST_OUT: begin
          if (i_rdy) begin
            vld_d   = 1'b0;
            state_d = ST_IDLE;
          end else begin
            vld_d   = 1'b1;
          end
        end
        default: begin
          state_d = ST_IDLE;
          a_rdy_d = 1'b0;
          vld_d   = 1'b0;
        end
      endcase
    end
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= {CNT_W{1'b0}};
      acc_q   <= {ACC_W{1'b0}};
      p_q     <= 16'h0000;
      p_v_q   <= 1'b0;
      a_rdy_q <= 1'b0;
      dat_q   <= 16'h0000;
      sat_q   <= 1'b0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      p_q     <= p_d;
      p_v_q   <= p_v_d;
      a_rdy_q <= a_rdy_d;
      dat_q   <= dat_d;
      sat_q   <= sat_d;
      vld_q   <= vld_d;
    end
  end

  assign o_a_rdy = a_rdy_q;
  assign o_dat   = dat_q;
  assign o_sat   = sat_q;
  assign o_vld   = vld_q;
  assign o_busy  = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mac_acc_16b.sv
// Directed self-checking bench for mac_acc_16b.
module tb_mac_acc_16b;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_clr = 1'b0;
  logic        i_start = 1'b0;
  logic [7:0]  i_len = 8'd0;
  logic        i_bias_en = 1'b0;
  logic [15:0] i_bias = 16'h0000;
  logic        i_a_vld = 1'b0;
  logic [7:0]  i_a = 8'd0;
  logic [7:0]  i_b = 8'd0;
  logic        o_a_rdy;
  logic [15:0] o_dat;
  logic        o_sat;
  logic        o_vld;
  logic        i_rdy = 1'b1;
  logic        o_busy;

  int total = 0;
  int bad = 0;

  mac_acc_16b dut (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_clr     (i_clr),
    .i_start   (i_start),
    .i_len     (i_len),
    .i_bias_en (i_bias_en),
    .i_bias    (i_bias),
    .i_a_vld   (i_a_vld),
    .i_a       (i_a),
    .i_b       (i_b),
    .o_a_rdy   (o_a_rdy),
    .o_dat     (o_dat),
    .o_sat     (o_sat),
    .o_vld     (o_vld),
    .i_rdy     (i_rdy),
    .o_busy    (o_busy)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic start(input logic [7:0] len, input logic ben, input logic [15:0] bias);
    i_start   = 1'b1;
    i_len     = len;
    i_bias_en = ben;
    i_bias    = bias;
    tick();
    i_start   = 1'b0;
  endtask

  task automatic feed(input logic [7:0] a, input logic [7:0] b);
    i_a_vld = 1'b1;
    i_a     = a;
    i_b     = b;
    tick();
    i_a_vld = 1'b0;
  endtask

  initial begin
    int beats;
    int vld_seen;

    // Reset values
    #12;
    chk("rst_vld",  o_vld,   1'b0);
    chk("rst_rdy",  o_a_rdy, 1'b0);
    chk("rst_busy", o_busy,  1'b0);
    chk("rst_dat",  o_dat,   16'h0000);
    chk("rst_sat",  o_sat,   1'b0);
    tick();
    i_rst_n = 1'b1;
    tick();

    // T1: 1*2 + 3*4 + (-5)*6 + 7*(-8) = 2+12-30-56 = -72 = 0xFFB8
    start(8'd4, 1'b0, 16'h0000);
    chk("t1_rdy_after_start", o_a_rdy, 1'b1);
    chk("t1_busy", o_busy, 1'b1);
    feed(8'd1, 8'd2);
    feed(8'd3, 8'd4);
    feed(8'hFB, 8'd6);
    feed(8'd7, 8'hF8);
    chk("t1_rdy_drop", o_a_rdy, 1'b0);
    chk("t1_vld_early", o_vld, 1'b0);
    tick();
    chk("t1_vld", o_vld, 1'b1);
    chk("t1_dat", o_dat, 16'hFFB8);
    chk("t1_sat", o_sat, 1'b0);
    tick();
    chk("t1_vld_clr", o_vld, 1'b0);
    chk("t1_idle", o_busy, 1'b0);

    // T2: 3*16129 + 100 = 48487 -> 0x7FFF clipped
    start(8'd3, 1'b1, 16'd100);
    feed(8'd127, 8'd127);
    feed(8'd127, 8'd127);
    feed(8'd127, 8'd127);
    tick();
    chk("t2_vld", o_vld, 1'b1);
    chk("t2_dat", o_dat, 16'h7FFF);
    chk("t2_sat", o_sat, 1'b1);
    tick();

    // T3: len 0 -> 256 terms of 16384 = 4194304 -> 0x7FFF clipped
    start(8'd0, 1'b0, 16'h0000);
    beats   = 0;
    i_a_vld = 1'b1;
    i_a     = 8'h80;
    i_b     = 8'h80;
    for (int i = 0; i < 300; i++) begin
      if (o_a_rdy) beats++;
      tick();
      if (!o_a_rdy) break;
    end
    i_a_vld = 1'b0;
    chk("t3_beats", beats, 32'd256);
    chk("t3_rdy_drop", o_a_rdy, 1'b0);
    chk("t3_vld_early", o_vld, 1'b0);
    tick();
    chk("t3_vld", o_vld, 1'b1);
    chk("t3_dat", o_dat, 16'h7FFF);
    chk("t3_sat", o_sat, 1'b1);
    tick();

    // T4: -32768 + 2*(-16256) = -65280 -> 0x8000 clipped; backpressure hold
    i_rdy = 1'b0;
    start(8'd2, 1'b1, 16'h8000);
    feed(8'h80, 8'd127);
    feed(8'h80, 8'd127);
    tick();
    chk("t4_vld", o_vld, 1'b1);
    chk("t4_dat", o_dat, 16'h8000);
    chk("t4_sat", o_sat, 1'b1);
    for (int i = 0; i < 5; i++) begin
      i_start = (i == 2);
      i_len   = 8'd5;
      tick();
      chk("t4_hold_vld", o_vld, 1'b1);
      chk("t4_hold_dat", o_dat, 16'h8000);
      chk("t4_no_rdy", o_a_rdy, 1'b0);
    end
    i_start = 1'b0;
    i_rdy   = 1'b1;
    tick();
    chk("t4_vld_clr", o_vld, 1'b0);
    chk("t4_idle", o_busy, 1'b0);

    // T5: abort after 3 beats with toggling valid, then len 1, 2*3 = 6
    start(8'd8, 1'b0, 16'h0000);
    for (int i = 0; i < 3; i++) begin
      feed(8'd1, 8'd1);
      tick();
    end
    i_clr = 1'b1;
    tick();
    i_clr = 1'b0;
    chk("t5_busy", o_busy, 1'b0);
    chk("t5_rdy", o_a_rdy, 1'b0);
    vld_seen = 0;
    for (int i = 0; i < 10; i++) begin
      i_a_vld = (i % 2 == 0);
      tick();
      if (o_vld) vld_seen++;
    end
    i_a_vld = 1'b0;
    chk("t5_no_vld", vld_seen, 32'd0);
    start(8'd1, 1'b0, 16'h0000);
    feed(8'd2, 8'd3);
    tick();
    chk("t5_vld", o_vld, 1'b1);
    chk("t5_dat", o_dat, 16'h0006);
    chk("t5_sat", o_sat, 1'b0);
    tick();

    // T6: async reset while in OUT
    i_rdy = 1'b0;
    start(8'd1, 1'b0, 16'h0000);
    feed(8'd10, 8'd10);
    tick();
    chk("t6_vld_pre", o_vld, 1'b1);
    chk("t6_dat_pre", o_dat, 16'h0064);
    #2;
    i_rst_n = 1'b0;
    #1;
    chk("t6_rst_vld", o_vld, 1'b0);
    chk("t6_rst_dat", o_dat, 16'h0000);
    chk("t6_rst_busy", o_busy, 1'b0);
    #3;
    i_rst_n = 1'b1;
    i_rdy   = 1'b1;
    tick();
    chk("t6_idle", o_busy, 1'b0);
    chk("t6_rdy", o_a_rdy, 1'b0);
    // (-3)*5 = -15 = 0xFFF1
    start(8'd1, 1'b0, 16'h0000);
    feed(8'hFD, 8'd5);
    tick();
    chk("t6_after_vld", o_vld, 1'b1);
    chk("t6_after_dat", o_dat, 16'hFFF1);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
